// File: rtl/local_inject_ctrl_pkg.sv
// Shared widths, state encodings and queue entry layout for the local inject controller.
package local_inject_ctrl_pkg;

  localparam int unsigned WIDTH_PORT            = 16;
  localparam int unsigned WIDTH_PV              = 5;
  localparam int unsigned NUM_CHANNEL           = 5;
  localparam int unsigned LIC_STARVE_TH_DEFAULT = 16;

  typedef enum logic [1:0] {
    LIC_IDLE   = 2'd0,
    LIC_WAIT   = 2'd1,
    LIC_STARVE = 2'd2
  } lic_state_e;

  typedef struct packed {
    logic [WIDTH_PV-1:0]   pv;
    logic [WIDTH_PORT-1:0] flit;
  } lic_entry_t;

endpackage

// File: rtl/local_inject_ctrl_local_fifo.sv
// Power-of-two circular queue holding {pv, flit} entries; head is read straight from storage.
module local_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 21
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/local_inject_ctrl.sv
// Local PE inject controller: queues PE flits, presents the head to the inject stage,
// and tracks head wait time to flag starvation.
module local_inject_ctrl
  import local_inject_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STARVE_TH = LIC_STARVE_TH_DEFAULT,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pe_valid,
  input  logic [WIDTH_PORT-1:0] pe_flit,
  input  logic [WIDTH_PV-1:0]   pe_pv,
  output logic                  pe_ready,
  output logic [WIDTH_PORT-1:0] dinLocal,
  output logic [WIDTH_PV-1:0]   PVLocal,
  output logic                  localValid,
  input  logic [WIDTH_PV-1:0]   injectVector,
  output logic                  starve,
  output logic [CNT_W-1:0]      wait_cnt,
  output logic [15:0]           inj_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(lic_entry_t);

  lic_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             starve_q, starve_d;
  logic [15:0]      inj_count_q, inj_count_d;

  logic             push, inject, drains_c;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [EW-1:0]    fifo_head;
  lic_entry_t       wr_entry, head_entry;
  logic [CNT_W-1:0] wait_inc;

  assign pe_ready   = ~fifo_full;
  assign localValid = ~fifo_empty;
  assign push       = pe_valid & pe_ready;
  assign inject     = localValid & (|injectVector);
  // Queue goes empty at this edge: last entry retires with nothing arriving behind it.
  assign drains_c   = inject & (fifo_count == CW'(1)) & ~push;
  assign wait_inc   = wait_cnt_q + CNT_W'(1);

  assign wr_entry   = '{pv: pe_pv, flit: pe_flit};
  assign head_entry = lic_entry_t'(fifo_head);
  assign dinLocal   = head_entry.flit;
  assign PVLocal    = head_entry.pv;

  local_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (inject),
    .din   (wr_entry),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LIC_IDLE;
      wait_cnt_q  <= '0;
      starve_q    <= 1'b0;
      inj_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      inj_count_q <= inj_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LIC_IDLE:   if (push) state_d = LIC_WAIT;
      LIC_WAIT: begin
        if (inject)                                state_d = drains_c ? LIC_IDLE : LIC_WAIT;
        else if (wait_inc == CNT_W'(STARVE_TH))   state_d = LIC_STARVE;
      end
      LIC_STARVE: if (inject) state_d = drains_c ? LIC_IDLE : LIC_WAIT;
      default:    state_d = LIC_IDLE;
    endcase
  end

  // Wait count saturates in STARVE; any retire restarts timing for the next head.
  always_comb begin
    wait_cnt_d  = '0;
    starve_d    = (state_d == LIC_STARVE);
    inj_count_d = inj_count_q + 16'(inject);
    case (state_q)
      LIC_WAIT:   wait_cnt_d = inject ? '0 : wait_inc;
      LIC_STARVE: wait_cnt_d = inject ? '0 : wait_cnt_q;
      default:    wait_cnt_d = '0;
    endcase
  end

  assign starve    = starve_q;
  assign wait_cnt  = wait_cnt_q;
  assign inj_count = inj_count_q;

endmodule
